reset_request: RTL and testbench
================================

RESET_REQUEST -- requirements
Module: reset_request

Interface
REQ-001 SHALL have parameters: DEBOUNCE_CYCLES, default 16, stable cycles for button accept; PULSE_CYCLES, default 4, request low width; WDOG_LIMIT, default 65535, watchdog expiry count; SEQ_TIMEOUT, default 64, max cycles awaiting sequencer; HOLDOFF_CYCLES, default 32, post-reset request lockout.
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-low:
  SYSTEM_CLOCK  in  1  sole clock
  SYSTEM_RESET_N  in  1  async active-low reset
  BUTTON_N  in  1  raw console reset button, asynchronous, active-low
  SW_RESET_REQ  in  1  maintenance-channel reset request, held until acknowledged
  SW_RESET_ACK  out  1  one-cycle acknowledge of SW_RESET_REQ
  WDOG_ENABLE  in  1  watchdog armed
  WDOG_KICK  in  1  watchdog restart strobe
  SYSTEM_RESET  in  1  sequencer feedback, system reset active
  CPU_RESET  in  1  sequencer feedback, CPU reset active
  RESET_REQUEST_N  out  1  active-low request to reset sequencer
  RESET_CAUSE  out  2  last cause: 0 none, 1 button, 2 watchdog, 3 software
  SEQ_FAULT  out  1  sequencer failed to complete within SEQ_TIMEOUT
  BUSY  out  1  high in any state except IDLE

Function
REQ-003 BUTTON_N SHALL pass a two-flop synchronizer; press accepted after DEBOUNCE_CYCLES consecutive low samples, one event per press; next press requires DEBOUNCE_CYCLES consecutive high samples first.
REQ-004 Watchdog counter SHALL clear on WDOG_KICK or WDOG_ENABLE low, increment otherwise, raise expiry at count == WDOG_LIMIT, saturate there; cleared on entry to ASSERT.
REQ-005 FSM states: IDLE, ASSERT, WAIT_RISE, WAIT_FALL, HOLDOFF.
REQ-006 IDLE -> ASSERT on any pending event; priority button > watchdog > software; RESET_CAUSE latched on transition.
REQ-007 ASSERT SHALL drive RESET_REQUEST_N low exactly PULSE_CYCLES cycles, starting the cycle after the event is registered, then -> WAIT_RISE.
REQ-008 WAIT_RISE -> WAIT_FALL when CPU_RESET seen high; WAIT_FALL -> HOLDOFF when both SYSTEM_RESET and CPU_RESET low.
REQ-009 One timeout counter SHALL span WAIT_RISE+WAIT_FALL; at SEQ_TIMEOUT cycles set SEQ_FAULT (sticky until reset) and -> HOLDOFF.
REQ-010 HOLDOFF SHALL last HOLDOFF_CYCLES then -> IDLE; events arriving in ASSERT/WAIT/HOLDOFF SHALL be discarded, except SW_RESET_REQ, which stays pending.
REQ-011 SW_RESET_ACK SHALL pulse one cycle on the IDLE->ASSERT transition caused by software; never otherwise.
REQ-012 Simultaneous events SHALL produce one request only; losing events discarded (software stays pending per REQ-010).
REQ-013 RESET_CAUSE SHALL hold its value through later IDLE periods until the next request.

Reset
REQ-014 On SYSTEM_RESET_N low, asynchronously: state IDLE, RESET_REQUEST_N 1, SW_RESET_ACK 0, RESET_CAUSE 0, SEQ_FAULT 0, BUSY 0, all counters 0, synchronizer flops 1.
REQ-015 Reset mid-operation SHALL abort any request immediately; RESET_REQUEST_N returns high same instant.
REQ-016 Deassertion of SYSTEM_RESET_N SHALL be synchronized externally; block needs no internal release logic.

Structure
REQ-017 Cause encodings, FSM state encodings and default parameter values SHALL reside in the shared Cray construction include file.
REQ-018 Button synchronizer+debouncer SHALL be one sub-module, reset_debounce; FSM, watchdog, timers stay top-level.

Verification (DEBOUNCE 4, PULSE 4, WDOG_LIMIT 20, SEQ_TIMEOUT 16, HOLDOFF 8)
REQ-019 BUTTON_N low 10 cycles -> RESET_REQUEST_N low 4 cycles, RESET_CAUSE=1; 3-cycle glitch -> no request.
REQ-020 WDOG_ENABLE=1, no kick -> request after 20 cycles, RESET_CAUSE=2; kick every 10 cycles -> never.
REQ-021 SW_RESET_REQ held -> one SW_RESET_ACK pulse, RESET_CAUSE=3; request during HOLDOFF served after HOLDOFF ends.
REQ-022 Button and software same cycle -> one pulse, RESET_CAUSE=1, software served after HOLDOFF.
REQ-023 CPU_RESET never rises -> SEQ_FAULT=1 16 cycles after pulse end, return to IDLE after 8 more.
REQ-024 SYSTEM_RESET_N low during ASSERT -> RESET_REQUEST_N high at once, all outputs at reset values.

Source files
------------

// File: rtl/reset_request_pkg.sv
// Shared encodings and defaults for the reset request block.
// States, cause codes and the counter-width helper live here.
package reset_request_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_WDOG   = 2'd2,
        CAUSE_SW     = 2'd3
    } cause_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PULSE_CYCLES    = 4;
    localparam int DEF_WDOG_LIMIT      = 65535;
    localparam int DEF_SEQ_TIMEOUT     = 64;
    localparam int DEF_HOLDOFF_CYCLES  = 32;

    // Bits needed to hold values 0..n
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Console button synchronizer and debouncer.
// Emits one press pulse per accepted low level of the button.
module reset_debounce
    import reset_request_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    output logic press
);

    localparam int CW = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Two-flop sync, then flip the stable level after CYCLES
    // consecutive samples disagreeing with it; pulse on press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_request.sv
// Reset request arbiter: button, watchdog and software causes
// feed one request pulse to the reset sequencer.
module reset_request
    import reset_request_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int WDOG_LIMIT      = DEF_WDOG_LIMIT,
    parameter int SEQ_TIMEOUT     = DEF_SEQ_TIMEOUT,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic       SYSTEM_CLOCK,
    input  logic       SYSTEM_RESET_N,
    input  logic       BUTTON_N,
    input  logic       SW_RESET_REQ,
    output logic       SW_RESET_ACK,
    input  logic       WDOG_ENABLE,
    input  logic       WDOG_KICK,
    input  logic       SYSTEM_RESET,
    input  logic       CPU_RESET,
    output logic       RESET_REQUEST_N,
    output logic [1:0] RESET_CAUSE,
    output logic       SEQ_FAULT,
    output logic       BUSY
);

    localparam int TMAX12 = (PULSE_CYCLES > SEQ_TIMEOUT) ?
                            PULSE_CYCLES : SEQ_TIMEOUT;
    localparam int TMAX   = (TMAX12 > HOLDOFF_CYCLES) ?
                            TMAX12 : HOLDOFF_CYCLES;
    localparam int TW     = cnt_width(TMAX);
    localparam int WW     = cnt_width(WDOG_LIMIT);

    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] SEQ_LAST   = TW'(SEQ_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(WDOG_LIMIT);

    state_t        state;
    state_t        state_next;
    cause_t        cause;
    cause_t        cause_next;
    logic          ack_next;
    logic          fault_set;
    logic          fault;
    logic          req_n;
    logic          sw_ack;
    logic          press;
    logic [TW-1:0] tmr;
    logic          tmr_clr;
    logic [WW-1:0] wdog_cnt;
    logic          wdog_exp;
    logic          enter_assert;

    reset_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (SYSTEM_CLOCK),
        .rst_n    (SYSTEM_RESET_N),
        .button_n (BUTTON_N),
        .press    (press)
    );

    assign wdog_exp     = (wdog_cnt == WDOG_MAX);
    assign enter_assert = (state_next == ST_ASSERT) &&
                          (state != ST_ASSERT);
    // The timeout window spans both wait states, so no clear there
    assign tmr_clr      = (state_next != state) &&
                          !(state == ST_WAIT_RISE &&
                            state_next == ST_WAIT_FALL);

    // Next-state, cause capture and ack decision
    always_comb begin
        state_next = state;
        cause_next = cause;
        ack_next   = 1'b0;
        fault_set  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (press) begin
                    state_next = ST_ASSERT;
                    cause_next = CAUSE_BUTTON;
                end else if (wdog_exp) begin
                    state_next = ST_ASSERT;
                    cause_next = CAUSE_WDOG;
                end else if (SW_RESET_REQ) begin
                    state_next = ST_ASSERT;
                    cause_next = CAUSE_SW;
                    ack_next   = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (tmr == PULSE_LAST) state_next = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (tmr == SEQ_LAST) begin
                    state_next = ST_HOLDOFF;
                    fault_set  = 1'b1;
                end else if (CPU_RESET) begin
                    state_next = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (tmr == SEQ_LAST) begin
                    state_next = ST_HOLDOFF;
                    fault_set  = 1'b1;
                end else if (!SYSTEM_RESET && !CPU_RESET) begin
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (tmr == HOLD_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge SYSTEM_CLOCK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state  <= ST_IDLE;
            cause  <= CAUSE_NONE;
            fault  <= 1'b0;
            req_n  <= 1'b1;
            sw_ack <= 1'b0;
        end else begin
            state  <= state_next;
            cause  <= cause_next;
            fault  <= fault | fault_set;
            req_n  <= (state_next != ST_ASSERT);
            sw_ack <= ack_next;
        end
    end

    // Shared phase timer: pulse width, sequencer timeout, holdoff
    always_ff @(posedge SYSTEM_CLOCK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            tmr <= '0;
        end else if (tmr_clr) begin
            tmr <= '0;
        end else if (state != ST_IDLE) begin
            tmr <= tmr + 1'b1;
        end
    end

    // Watchdog; an expiry seen while busy is dropped by clearing
    always_ff @(posedge SYSTEM_CLOCK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            wdog_cnt <= '0;
        end else if (!WDOG_ENABLE || WDOG_KICK || enter_assert ||
                     (wdog_exp && state != ST_IDLE)) begin
            wdog_cnt <= '0;
        end else if (!wdog_exp) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign RESET_REQUEST_N = req_n;
    assign SW_RESET_ACK    = sw_ack;
    assign RESET_CAUSE     = cause;
    assign SEQ_FAULT       = fault;
    assign BUSY            = (state != ST_IDLE);

endmodule

// File: tb/tb_reset_request.sv
// Directed bench for reset_request with small timing parameters.
// Latencies are counted in falling edges from the stimulus edge.
module tb_reset_request;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       button_n = 1'b1;
    logic       sw_req = 1'b0;
    logic       wdog_en = 1'b0;
    logic       kick = 1'b0;
    logic       sys_rst = 1'b0;
    logic       cpu_rst = 1'b0;
    logic       sw_ack;
    logic       req_n;
    logic [1:0] cause;
    logic       seq_fault;
    logic       busy;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;
    int req_low = 0;
    int n;
    int a0;

    reset_request #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (4),
        .WDOG_LIMIT      (20),
        .SEQ_TIMEOUT     (16),
        .HOLDOFF_CYCLES  (8)
    ) dut (
        .SYSTEM_CLOCK    (clk),
        .SYSTEM_RESET_N  (rst_n),
        .BUTTON_N        (button_n),
        .SW_RESET_REQ    (sw_req),
        .SW_RESET_ACK    (sw_ack),
        .WDOG_ENABLE     (wdog_en),
        .WDOG_KICK       (kick),
        .SYSTEM_RESET    (sys_rst),
        .CPU_RESET       (cpu_rst),
        .RESET_REQUEST_N (req_n),
        .RESET_CAUSE     (cause),
        .SEQ_FAULT       (seq_fault),
        .BUSY            (busy)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the rising edge (pre-update values)
    always @(posedge clk) begin
        if (sw_ack) ack_seen++;
        if (!req_n) req_low++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return req_n;
            1:       return sw_ack;
            2:       return busy;
            default: return seq_fault;
        endcase
    endfunction

    // Count falling edges until the probed signal equals val
    task automatic wait_until(input int sel, input logic val,
                              input int budget, output int cnt);
        cnt = 0;
        while (probe(sel) != val && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Sequencer model: reset pulse of three cycles
    task automatic respond();
        cpu_rst = 1'b1;
        sys_rst = 1'b1;
        tick(3);
        cpu_rst = 1'b0;
        sys_rst = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_n", req_n, 1);
        chk("rst_ack", sw_ack, 0);
        chk("rst_cause", cause, 0);
        chk("rst_fault", seq_fault, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);

        // three-cycle glitch is rejected
        button_n = 1'b0;
        tick(3);
        button_n = 1'b1;
        wait_until(0, 1'b0, 15, n);
        chk("glitch_noreq", n, 15);

        // accepted button press
        button_n = 1'b0;
        wait_until(0, 1'b0, 30, n);
        chk("btn_lat", n, 7);
        chk("btn_cause", cause, 1);
        chk("btn_busy", busy, 1);
        wait_until(0, 1'b1, 30, n);
        chk("btn_width", n, 4);
        button_n = 1'b1;
        respond();
        wait_until(2, 1'b0, 40, n);
        chk("btn_idle", n, 9);
        tick(5);
        chk("btn_cause_hold", cause, 1);
        chk("btn_noack", ack_seen, 0);
        chk("btn_nofault", seq_fault, 0);

        // watchdog expiry without kicks
        wdog_en = 1'b1;
        wait_until(0, 1'b0, 40, n);
        chk("wd_lat", n, 21);
        chk("wd_cause", cause, 2);
        wait_until(0, 1'b1, 30, n);
        chk("wd_width", n, 4);
        wdog_en = 1'b0;
        respond();
        wait_until(2, 1'b0, 40, n);
        chk("wd_idle", n, 9);

        // kick every ten cycles keeps it quiet
        a0 = req_low;
        wdog_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(9);
            kick = 1'b1;
            tick(1);
            kick = 1'b0;
        end
        chk("kick_noreq", req_low - a0, 0);
        chk("kick_idle", busy, 0);
        wdog_en = 1'b0;
        tick(2);

        // software request, then another during holdoff
        a0 = ack_seen;
        sw_req = 1'b1;
        wait_until(1, 1'b1, 20, n);
        chk("sw_lat", n, 1);
        sw_req = 1'b0;
        chk("sw_cause", cause, 3);
        chk("sw_req_low", req_n, 0);
        wait_until(0, 1'b1, 30, n);
        chk("sw_width", n, 4);
        chk("sw_one_ack", ack_seen - a0, 1);
        respond();
        tick(2);
        sw_req = 1'b1;
        wait_until(1, 1'b1, 30, n);
        chk("sw_hold_lat", n, 8);
        sw_req = 1'b0;
        wait_until(0, 1'b1, 30, n);
        chk("sw_hold_width", n, 4);
        respond();
        wait_until(2, 1'b0, 40, n);
        chk("sw_hold_idle", n, 9);

        // button and software in the same cycle
        a0 = ack_seen;
        button_n = 1'b0;
        tick(6);
        sw_req = 1'b1;
        wait_until(0, 1'b0, 10, n);
        chk("both_lat", n, 1);
        chk("both_cause", cause, 1);
        wait_until(0, 1'b1, 30, n);
        chk("both_width", n, 4);
        chk("both_noack", ack_seen - a0, 0);
        button_n = 1'b1;
        respond();
        wait_until(1, 1'b1, 40, n);
        chk("both_sw_lat", n, 10);
        chk("both_sw_cause", cause, 3);
        sw_req = 1'b0;
        wait_until(0, 1'b1, 30, n);
        respond();
        wait_until(2, 1'b0, 40, n);
        chk("both_one_ack", ack_seen - a0, 1);

        // sequencer never answers
        button_n = 1'b0;
        wait_until(0, 1'b0, 30, n);
        chk("to_lat", n, 7);
        wait_until(0, 1'b1, 30, n);
        button_n = 1'b1;
        wait_until(3, 1'b1, 40, n);
        chk("to_fault_lat", n, 16);
        chk("to_busy", busy, 1);
        wait_until(2, 1'b0, 40, n);
        chk("to_idle", n, 8);
        chk("to_sticky", seq_fault, 1);

        // reset asserted in the middle of a request pulse
        sw_req = 1'b1;
        wait_until(1, 1'b1, 20, n);
        sw_req = 1'b0;
        tick(1);
        chk("abort_pre", req_n, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_req_n", req_n, 1);
        chk("abort_ack", sw_ack, 0);
        chk("abort_cause", cause, 0);
        chk("abort_fault", seq_fault, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);
        chk("post_req_n", req_n, 1);
        chk("post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
